regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single writeback port of the banked main-core register block between NUM_REQ writeback requesters, e.g. ALU, load unit and coprocessor return path.
- Uses round-robin arbitration with a registered output stage that drives rd, rd value, writeback bank select and the writeback strobe.
- Flags read-after-write hazards between the current read addresses and pending writebacks.
- Detects and drops requests targeting the reserved bank encoding 2'b11, and records a sticky error.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 32, writeback data width.
- PTR_W, 2, round-robin pointer width; must satisfy 2^PTR_W >= NUM_REQ.

Ports:
- clk_in  in  1  core clock.
- reset_in  in  1  reset, synchronous and active-low.
- req_valid_in  in  NUM_REQ  per-requester writeback valid.
- req_ready_out  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_rd_in  in  NUM_REQ*5  packed destination register index, requester i at [5i+4:5i].
- req_bank_in  in  NUM_REQ*5  packed writeback bank select, bit 2 = upper/lower half, [1:0] = bank.
- req_val_in  in  NUM_REQ*DATA_W  packed writeback data.
- stall_in  in  1  pipeline freeze; blocks new grants.
- bank_sel_in  in  4  current read bank select (bits [1:0] compared).
- rsa_in  in  5  current read address A.
- rsb_in  in  5  current read address B.
- wb_out  out  1  writeback strobe to register block.
- wb_rd_out  out  5  writeback destination.
- wb_val_out  out  DATA_W  writeback data.
- wb_bank_sel_out  out  5  writeback bank select.
- hazard_a_out  out  1  rsa matches a pending writeback.
- hazard_b_out  out  1  rsb matches a pending writeback.
- err_out  out  1  sticky: a reserved-bank request was dropped.
- err_clr_in  in  1  clears err_out.
- grant_id_out  out  PTR_W  index of the last granted requester.

Behaviour:
- Reset (reset_in = 0 at a clk_in edge) sets every registered output to 0 and sets the round-robin pointer to NUM_REQ-1, so requester 0 has highest priority first.
- req_ready_out is combinational from reset_in, stall_in, req_valid_in and the pointer. It is 0 while reset_in = 0.
- Arbitration: when stall_in = 0, search from pointer+1 upward with wrap at NUM_REQ-1 back to 0. The first valid requester wins. Its ready bit is 1; all other ready bits are 0.
- When stall_in = 1, req_ready_out = 0 and no grant occurs.
- A handshake (valid & ready) completes in that cycle. The requester must hold rd, bank and data stable while valid = 1 and ready = 0.
- Latency: a grant at edge N produces wb_out = 1 with the granted fields in the cycle after edge N.
- wb_out is a one-cycle pulse per grant. Back-to-back grants give consecutive pulses.
- When there is no grant, wb_out = 0 at the next edge and the data/rd/bank outputs hold their last values.
- The pointer updates to the granted index on every completed handshake, including dropped reserved-bank requests. grant_id_out mirrors the pointer.
- Reserved bank: a granted request with bank[1:0] = 2'b11 is accepted (ready = 1) but produces no wb_out, and err_out sets at the next edge.
- err_out: set has priority over err_clr_in in the same cycle. Otherwise err_clr_in = 1 clears it at the next edge.
- Hazards (combinational): hazard_a_out = 1 if either of these matches rsa_in with the same bank[1:0] as bank_sel_in[1:0]:
  - the output stage (wb_out = 1, wb_rd_out, wb_bank_sel_out[1:0]);
  - any req_valid_in[i] with a non-reserved bank (req_rd, req_bank[1:0]).
- hazard_b_out is the same check against rsb_in.
- Read bank 2'b11 never hazards.
- Same-register collisions between requesters are not merged. They are serviced in round-robin order, so the later grant wins in the register file.
- Reset mid-operation discards any in-flight output-stage write: wb_out = 0 in the cycle after the reset edge.

Decomposition:
- Shared package regfile_pkg holds:
  - bank encodings: BANK_GP = 2'b00, BANK_SYS = 2'b01, BANK_GBL = 2'b10, BANK_RSVD = 2'b11;
  - REG_IDX_W = 5 and BANK_SEL_W = 5;
  - the writeback request struct {rd, bank, val}.
- One sub-module: rr_arbiter, a parameterised round-robin one-hot grant generator with inputs req, pointer and enable, and outputs grant and grant index. It is reused elsewhere.
- Hazard compare and the output register stay in the top module.

Test Plan:
- Single request: req_valid = 3'b001, rd = 5, bank = 5'b00000, val = 32'hDEADBEEF -> ready[0] same cycle; next cycle wb_out = 1, wb_rd_out = 5, wb_val_out = 32'hDEADBEEF, for one cycle only.
- Fairness: all three requesters valid continuously for 6 cycles after reset -> grant order 0,1,2,0,1,2; wb_out high for 6 consecutive cycles.
- Stall: requesters 1 and 2 valid, stall_in = 1 for 3 cycles -> ready = 0 and wb_out = 0 throughout; first cycle after release grants 1, then 2.
- Reserved bank: requester 2 with bank = 5'b00011 -> ready[2] = 1, no wb_out, err_out = 1 next cycle; err_clr_in pulse -> err_out = 0 the following cycle.
- Hazard: wb output stage rd = 7 in bank SYS (01); rsa_in = 7, bank_sel_in = 4'b0001 -> hazard_a_out = 1; the same with bank_sel_in = 4'b0000 -> 0; rsb_in = 9 with a pending GP request on rd 9 -> hazard_b_out = 1.
- Reset mid-stream: assert reset_in = 0 during continuous grants -> next cycle wb_out = 0, ready = 0, grant_id_out = NUM_REQ-1; first grant after release goes to requester 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the main-core register block writeback path:
// bank encodings, field widths and the writeback request record.
package regfile_pkg;

   localparam int REG_IDX_W  = 5;
   localparam int BANK_SEL_W = 5;
   localparam int WB_DATA_W  = 32;

   // Encodings of bank_sel[1:0]; bit 2 of a bank select picks the upper/lower half.
   typedef enum logic [1:0] {
      BANK_GP   = 2'b00,
      BANK_SYS  = 2'b01,
      BANK_GBL  = 2'b10,
      BANK_RSVD = 2'b11
   } bank_e;

   // One writeback request as seen by the register block.
   typedef struct packed {
      logic [REG_IDX_W-1:0]  rd;
      logic [BANK_SEL_W-1:0] bank;
      logic [WB_DATA_W-1:0]  val;
   } wb_req_t;

   // True when a bank select targets the reserved encoding.
   function automatic logic is_rsvd(input logic [BANK_SEL_W-1:0] bank);
      return bank[1:0] == BANK_RSVD;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant generator. The search starts one past ptr and
// wraps at N-1; the first requesting index wins. ptr must be below N.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx
);

   // Walk the N candidates in priority order and keep the first requester.
   always_comb begin
      logic found;
      int   idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register block's single writeback port between NUM_REQ
// requesters: round-robin grant, one registered output stage, read-after-write
// hazard flags and a sticky error for requests to the reserved bank.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = WB_DATA_W,
   parameter int PTR_W   = 2
) (
   input  logic                          clk_in,
   input  logic                          reset_in,
   input  logic [NUM_REQ-1:0]            req_valid_in,
   output logic [NUM_REQ-1:0]            req_ready_out,
   input  logic [NUM_REQ*REG_IDX_W-1:0]  req_rd_in,
   input  logic [NUM_REQ*BANK_SEL_W-1:0] req_bank_in,
   input  logic [NUM_REQ*DATA_W-1:0]     req_val_in,
   input  logic                          stall_in,
   input  logic [3:0]                    bank_sel_in,
   input  logic [REG_IDX_W-1:0]          rsa_in,
   input  logic [REG_IDX_W-1:0]          rsb_in,
   output logic                          wb_out,
   output logic [REG_IDX_W-1:0]          wb_rd_out,
   output logic [DATA_W-1:0]             wb_val_out,
   output logic [BANK_SEL_W-1:0]         wb_bank_sel_out,
   output logic                          hazard_a_out,
   output logic                          hazard_b_out,
   output logic                          err_out,
   input  logic                          err_clr_in,
   output logic [PTR_W-1:0]              grant_id_out
);

   // Handshake: requester i transfers in any cycle where req_valid_in[i] and
   // req_ready_out[i] are both 1. While valid is 1 and ready is 0 the requester
   // holds rd, bank and val stable. Ready never depends on the data fields.

   wb_req_t            req [NUM_REQ];
   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   ptr_q;
   logic               arb_en;
   logic               handshake;
   logic               drop;
   wb_req_t            out_q;
   logic               wb_q;
   logic               err_q;
   logic               haz_a;
   logic               haz_b;
   logic               unused_bank_hi;

   // Unpack the flat request buses into per-requester records.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i].rd   = req_rd_in[i*REG_IDX_W +: REG_IDX_W];
         req[i].bank = req_bank_in[i*BANK_SEL_W +: BANK_SEL_W];
         req[i].val  = req_val_in[i*DATA_W +: DATA_W];
      end
   end

   assign arb_en = reset_in & ~stall_in;

   rr_arbiter #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr_arbiter (
      .req       (req_valid_in),
      .ptr       (ptr_q),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready_out = grant;
   assign handshake     = |grant;
   assign drop          = is_rsvd(req[grant_idx].bank);

   // Round-robin pointer follows every completed handshake, dropped ones included.
   always_ff @(posedge clk_in) begin
      if (!reset_in)      ptr_q <= PTR_W'(NUM_REQ - 1);
      else if (handshake) ptr_q <= grant_idx;
   end

   // Output stage: one-cycle strobe per accepted write; fields hold between writes.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         wb_q  <= 1'b0;
         out_q <= '0;
      end else begin
         wb_q <= handshake & ~drop;
         if (handshake && !drop) out_q <= req[grant_idx];
      end
   end

   // Sticky reserved-bank error; a new drop wins over a clear in the same cycle.
   always_ff @(posedge clk_in) begin
      if (!reset_in)              err_q <= 1'b0;
      else if (handshake && drop) err_q <= 1'b1;
      else if (err_clr_in)        err_q <= 1'b0;
   end

   // Compare both read ports against the output stage and every pending request.
   always_comb begin
      haz_a = 1'b0;
      haz_b = 1'b0;
      if (bank_sel_in[1:0] != BANK_RSVD) begin
         if (wb_q && out_q.bank[1:0] == bank_sel_in[1:0]) begin
            if (out_q.rd == rsa_in) haz_a = 1'b1;
            if (out_q.rd == rsb_in) haz_b = 1'b1;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_in[i] && !is_rsvd(req[i].bank) &&
                req[i].bank[1:0] == bank_sel_in[1:0]) begin
               if (req[i].rd == rsa_in) haz_a = 1'b1;
               if (req[i].rd == rsb_in) haz_b = 1'b1;
            end
         end
      end
   end

   // Upper read bank-select bits do not take part in hazard matching.
   assign unused_bank_hi = ^bank_sel_in[3:2];

   assign wb_out          = wb_q;
   assign wb_rd_out       = out_q.rd;
   assign wb_val_out      = out_q.val;
   assign wb_bank_sel_out = out_q.bank;
   assign hazard_a_out    = haz_a;
   assign hazard_b_out    = haz_b;
   assign err_out         = err_q;
   assign grant_id_out    = ptr_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed single-request and hazard sequences,
// a vector table for fairness/stall/reserved-bank/reset, then random traffic
// checked against a cycle-level reference model with an expected-write queue.
module tb_regfile_wb_arbiter;

   localparam int N    = 3;
   localparam int DW   = 32;
   localparam int SB_W = 5 + 5 + DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [N-1:0]    valid;
   logic [N-1:0]    ready;
   logic [4:0]      t_rd   [N];
   logic [4:0]      t_bank [N];
   logic [DW-1:0]   t_val  [N];
   logic [N*5-1:0]  rd_flat;
   logic [N*5-1:0]  bank_flat;
   logic [N*DW-1:0] val_flat;
   logic            stall;
   logic [3:0]      bank_sel;
   logic [4:0]      rsa;
   logic [4:0]      rsb;
   logic            wb;
   logic [4:0]      wb_rd;
   logic [DW-1:0]   wb_val;
   logic [4:0]      wb_bank;
   logic            haz_a;
   logic            haz_b;
   logic            err;
   logic            clr;
   logic [1:0]      gid;

   assign rd_flat   = {t_rd[2], t_rd[1], t_rd[0]};
   assign bank_flat = {t_bank[2], t_bank[1], t_bank[0]};
   assign val_flat  = {t_val[2], t_val[1], t_val[0]};

   regfile_wb_arbiter #(
      .NUM_REQ (N),
      .DATA_W  (DW),
      .PTR_W   (2)
   ) dut (
      .clk_in          (clk),
      .reset_in        (rst_n),
      .req_valid_in    (valid),
      .req_ready_out   (ready),
      .req_rd_in       (rd_flat),
      .req_bank_in     (bank_flat),
      .req_val_in      (val_flat),
      .stall_in        (stall),
      .bank_sel_in     (bank_sel),
      .rsa_in          (rsa),
      .rsb_in          (rsb),
      .wb_out          (wb),
      .wb_rd_out       (wb_rd),
      .wb_val_out      (wb_val),
      .wb_bank_sel_out (wb_bank),
      .hazard_a_out    (haz_a),
      .hazard_b_out    (haz_b),
      .err_out         (err),
      .err_clr_in      (clr),
      .grant_id_out    (gid)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change at posedge+1; outputs are sampled there or a few ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [SB_W-1:0] exp_q[$];
   int              m_ptr;
   int              m_win;
   logic            m_err;
   logic            m_wb;
   logic [4:0]      m_rd;
   logic [4:0]      m_bank;
   logic [DW-1:0]   m_val;

   // Winner: lowest valid index above the pointer, otherwise lowest valid index.
   task automatic model_comb();
      m_win = -1;
      if (rst_n && !stall) begin
         for (int i = m_ptr + 1; i < N; i++) if (valid[i] && m_win < 0) m_win = i;
         for (int i = 0; i <= m_ptr; i++)    if (valid[i] && m_win < 0) m_win = i;
      end
   endtask

   function automatic logic model_haz(input logic [4:0] rs);
      logic hit = 1'b0;
      if (bank_sel[1:0] == 2'b11) return 1'b0;
      if (m_wb && m_rd == rs && m_bank[1:0] == bank_sel[1:0]) hit = 1'b1;
      for (int i = 0; i < N; i++)
         if (valid[i] && t_bank[i][1:0] != 2'b11 && t_rd[i] == rs &&
             t_bank[i][1:0] == bank_sel[1:0]) hit = 1'b1;
      return hit;
   endfunction

   task automatic model_edge();
      logic set_err = 1'b0;
      if (!rst_n) begin
         m_ptr = N - 1; m_err = 1'b0; m_wb = 1'b0;
         m_rd = '0; m_bank = '0; m_val = '0;
         exp_q.delete();
      end else begin
         m_wb = 1'b0;
         if (m_win >= 0) begin
            m_ptr = m_win;
            if (t_bank[m_win][1:0] == 2'b11) set_err = 1'b1;
            else begin
               m_wb = 1'b1; m_rd = t_rd[m_win]; m_bank = t_bank[m_win]; m_val = t_val[m_win];
               exp_q.push_back({t_rd[m_win], t_bank[m_win], t_val[m_win]});
            end
         end
         if (set_err) m_err = 1'b1;
         else if (clr) m_err = 1'b0;
      end
   endtask

   task automatic check_regs();
      logic [SB_W-1:0] e;
      chk("rnd_wb_out", wb, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("rnd_wb_rd", wb_rd, e[SB_W-1 -: 5]);
         chk("rnd_wb_bank", wb_bank, e[DW+4 -: 5]);
         chk("rnd_wb_val", wb_val, e[DW-1:0]);
      end else begin
         chk("rnd_hold_rd", wb_rd, m_rd);
         chk("rnd_hold_bank", wb_bank, m_bank);
         chk("rnd_hold_val", wb_val, m_val);
      end
      chk("rnd_err", err, m_err);
      chk("rnd_gid", gid, m_ptr);
   endtask

   // One modelled clock cycle with the currently driven inputs.
   task automatic cycle();
      #1;
      model_comb();
      chk("rnd_ready", ready, (m_win >= 0) ? (64'd1 << m_win) : 64'd0);
      chk("rnd_haz_a", haz_a, model_haz(rsa));
      chk("rnd_haz_b", haz_b, model_haz(rsb));
      model_edge();
      tick();
      check_regs();
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      valid = '0; stall = 1'b0; clr = 1'b0;
      bank_sel = 4'b0011; rsa = '0; rsb = '0;
      for (int i = 0; i < N; i++) begin t_rd[i] = '0; t_bank[i] = '0; t_val[i] = '0; end
   endtask

   task automatic new_req(input int i);
      valid[i]  = 1'b1;
      t_rd[i]   = 5'($urandom_range(0, 7));
      t_bank[i] = 5'($urandom_range(0, 31));
      t_val[i]  = $urandom;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic         rst_n;
      logic [N-1:0] valid;
      logic         stall;
      logic         clr;
      logic [4:0]   bank2;
      logic [N-1:0] exp_ready;
      logic         exp_wb;
      logic [1:0]   exp_gid;
      logic         exp_err;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset
      rst_n = 1'b0;
      drive_idle();
      tick();
      rst_n = 1'b1;
      chk("rst_wb", wb, 0);
      chk("rst_rd", wb_rd, 0);
      chk("rst_val", wb_val, 0);
      chk("rst_bank", wb_bank, 0);
      chk("rst_err", err, 0);
      chk("rst_gid", gid, N - 1);

      // single request
      t_rd[0] = 5'd5; t_bank[0] = 5'b00000; t_val[0] = 32'hDEADBEEF; valid = 3'b001;
      #1 chk("single_ready", ready, 3'b001);
      tick();
      valid = '0;
      chk("single_wb", wb, 1);
      chk("single_rd", wb_rd, 5);
      chk("single_val", wb_val, 32'hDEADBEEF);
      chk("single_gid", gid, 0);
      tick();
      chk("single_pulse", wb, 0);
      chk("single_hold_rd", wb_rd, 5);
      chk("single_hold_val", wb_val, 32'hDEADBEEF);

      // hazard: output stage holds rd 7 in bank SYS
      t_rd[0] = 5'd7; t_bank[0] = 5'b00001; valid = 3'b001;
      tick();
      valid = '0; stall = 1'b1;
      rsa = 5'd7; bank_sel = 4'b0001;
      #1 chk("haz_a_sys", haz_a, 1);
      bank_sel = 4'b0000;
      #1 chk("haz_a_gp", haz_a, 0);
      t_rd[1] = 5'd9; t_bank[1] = 5'b00000; valid = 3'b010; rsb = 5'd9;
      #1 chk("haz_b_pending", haz_b, 1);
      bank_sel = 4'b0011;
      #1 chk("haz_b_rsvd_read", haz_b, 0);
      t_bank[1] = 5'b00011; bank_sel = 4'b0000;
      #1 chk("haz_b_rsvd_req", haz_b, 0);
      valid = '0; stall = 1'b0;
      tick();

      // table: fairness, stall, reserved bank, err set/clear priority, mid-stream reset
      tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b001, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b010, 1'b1, 2'd1, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b100, 1'b1, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b001, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b010, 1'b1, 2'd1, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b100, 1'b1, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b110, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b110, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b110, 1'b1, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b110, 1'b0, 1'b0, 5'b00000, 3'b010, 1'b1, 2'd1, 1'b0});
      tbl.push_back('{1'b1, 3'b100, 1'b0, 1'b0, 5'b00000, 3'b100, 1'b1, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b100, 1'b0, 1'b0, 5'b00011, 3'b100, 1'b0, 2'd2, 1'b1});
      tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b1, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b100, 1'b0, 1'b1, 5'b00011, 3'b100, 1'b0, 2'd2, 1'b1});
      tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b1, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b001, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b010, 1'b1, 2'd1, 1'b0});
      tbl.push_back('{1'b0, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd2, 1'b0});
      tbl.push_back('{1'b1, 3'b111, 1'b0, 1'b0, 5'b00000, 3'b001, 1'b1, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 2'd0, 1'b0});

      drive_idle();
      for (int i = 0; i < N; i++) begin
         t_rd[i]  = 5'(10 + i);
         t_val[i] = 32'hA000_0000 + 32'(i);
      end
      for (int r = 0; r < tbl.size(); r++) begin
         rst_n     = tbl[r].rst_n;
         valid     = tbl[r].valid;
         stall     = tbl[r].stall;
         clr       = tbl[r].clr;
         t_bank[2] = tbl[r].bank2;
         #1 chk($sformatf("tbl%0d_ready", r), ready, tbl[r].exp_ready);
         tick();
         chk($sformatf("tbl%0d_wb", r), wb, tbl[r].exp_wb);
         chk($sformatf("tbl%0d_gid", r), gid, tbl[r].exp_gid);
         chk($sformatf("tbl%0d_err", r), err, tbl[r].exp_err);
         if (tbl[r].exp_wb) begin
            chk($sformatf("tbl%0d_rd", r), wb_rd, 10 + tbl[r].exp_gid);
            chk($sformatf("tbl%0d_val", r), wb_val, 32'hA000_0000 + tbl[r].exp_gid);
         end
      end

      // random traffic against the model, starting from a reset cycle
      drive_idle();
      m_ptr = N - 1; m_wb = 1'b0; m_err = 1'b0; m_rd = '0; m_bank = '0; m_val = '0;
      rst_n = 1'b0;
      cycle();
      for (int c = 0; c < 3000; c++) begin
         rst_n    = ($urandom_range(0, 79) != 0);
         stall    = ($urandom_range(0, 4) == 0);
         clr      = ($urandom_range(0, 7) == 0);
         bank_sel = 4'($urandom_range(0, 15));
         rsa      = 5'($urandom_range(0, 7));
         rsb      = 5'($urandom_range(0, 7));
         for (int i = 0; i < N; i++)
            if (!valid[i] && $urandom_range(0, 2) == 0) new_req(i);
         cycle();
         if (m_win >= 0) begin
            if ($urandom_range(0, 1) == 0) valid[m_win] = 1'b0;
            else new_req(m_win);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
